// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack: default sizing constants, the
// depth derivation helper and the per-cycle operation encoding.
package lifo_pkg;

    // Default geometry used when the stack is instantiated without overrides.
    localparam int DEFAULT_ADDR_BITS = 2;
    localparam int DEFAULT_DATA_BITS = 4;

    // Number of entries addressable with the given pointer width.
    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // What the stack does in a given cycle once push/pop acceptance is known.
    // OP_REPLACE is a simultaneous accepted push and pop: the top entry is
    // read out and overwritten in place, occupancy is unchanged.
    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } lifo_op_e;

endpackage

// File: rtl/lifo_regfile.sv
// Storage array for the LIFO stack: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; the stack
// pointer alone decides which entries are meaningful.
module lifo_regfile
    import lifo_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int DEPTH = depth_of(ADDR_BITS);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with a single stack pointer (the occupancy count), a registered
// pop port, a combinational peek of the top entry, occupancy flags and sticky
// overflow/underflow error flags. One push and/or pop per clock.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int AF_LEVEL  = depth_of(ADDR_BITS) - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 pop_valid,
    output logic [DATA_BITS-1:0] top_data,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int                 DEPTH     = depth_of(ADDR_BITS);
    localparam logic [ADDR_BITS:0] DEPTH_CNT = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AF_CNT    = AF_LEVEL[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] CNT_ONE   = 1;
    localparam logic [ADDR_BITS-1:0] IDX_ONE = 1;

    logic [ADDR_BITS:0]   count_q;
    logic [ADDR_BITS:0]   count_next;
    logic [ADDR_BITS-1:0] top_idx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [DATA_BITS-1:0] rd_top;
    logic                 push_acc;
    logic                 pop_acc;
    logic                 wr_en;
    logic                 pop_data_en;
    logic                 overflow_q;
    logic                 underflow_q;
    lifo_op_e             op;

    // Occupancy decodes straight off the count, no added latency.
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);

    // A pop needs something on the stack; a push needs room unless the pop
    // in the same cycle frees the top slot for it.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    // Top entry sits one below the pointer. At full the low pointer bits wrap
    // to zero and the decrement lands on the last entry, as intended; at empty
    // the index is meaningless and the peek is forced to zero below.
    assign top_idx = count_q[ADDR_BITS-1:0] - IDX_ONE;

    // Classify this cycle's accepted operation.
    always_comb begin
        op = OP_NONE;
        case ({push_acc, pop_acc})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
    end

    // Derive the write port controls and the next pointer from the operation.
    always_comb begin
        wr_en       = 1'b0;
        wr_idx      = count_q[ADDR_BITS-1:0];
        count_next  = count_q;
        pop_data_en = 1'b0;
        case (op)
            OP_PUSH: begin
                wr_en      = 1'b1;
                wr_idx     = count_q[ADDR_BITS-1:0];
                count_next = count_q + CNT_ONE;
            end
            OP_POP: begin
                pop_data_en = 1'b1;
                count_next  = count_q - CNT_ONE;
            end
            OP_REPLACE: begin
                wr_en       = 1'b1;
                wr_idx      = top_idx;
                pop_data_en = 1'b1;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    lifo_regfile #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (push_data),
        .rd_addr (top_idx),
        .rd_data (rd_top)
    );

    // Stack pointer and registered pop port; reset discards this cycle's ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            count_q   <= count_next;
            pop_valid <= pop_data_en;
            if (pop_data_en) begin
                pop_data <= rd_top;
            end
        end
    end

    // Sticky error flags; a fresh error outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !push_acc) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (pop && empty) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign top_data  = empty ? '0 : rd_top;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (ADDR_BITS=2, DATA_BITS=4, AF_LEVEL=3).
// Stimulus pushes expected popped words into a scoreboard queue; a monitor on
// the falling edge compares them whenever pop_valid is presented.
module tb_lifo_stack;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [3:0] push_data;
    logic       clr_err;
    logic [3:0] pop_data;
    logic       pop_valid;
    logic [3:0] top_data;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [3:0] model_q [$];
    logic [3:0] sb_q [$];
    logic       model_ov = 1'b0;
    logic       model_un = 1'b0;
    logic       model_valid = 1'b0;

    lifo_stack #(
        .ADDR_BITS (2),
        .DATA_BITS (4),
        .AF_LEVEL  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .push_data   (push_data),
        .clr_err     (clr_err),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .top_data    (top_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every observable against the reference LIFO model.
    task automatic checkState(input string tag);
        int sz;
        sz = model_q.size();
        checkOutput({tag, ".count"}, count, sz);
        checkOutput({tag, ".empty"}, empty, (sz == 0));
        checkOutput({tag, ".full"}, full, (sz == 4));
        checkOutput({tag, ".almost_full"}, almost_full, (sz >= 3));
        checkOutput({tag, ".top_data"}, top_data, (sz == 0) ? 4'd0 : model_q[sz-1]);
        checkOutput({tag, ".overflow"}, overflow, model_ov);
        checkOutput({tag, ".underflow"}, underflow, model_un);
        checkOutput({tag, ".pop_valid"}, pop_valid, model_valid);
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check state.
    task automatic applyStimulus(input logic p_push, input logic p_pop, input logic [3:0] p_data,
                                 input logic p_clr, input logic p_rst, input string tag);
        int  sz;
        logic pa;
        logic wa;
        push      = p_push;
        pop       = p_pop;
        push_data = p_data;
        clr_err   = p_clr;
        rst       = p_rst;
        sz = model_q.size();
        if (p_rst) begin
            model_q.delete();
            model_ov    = 1'b0;
            model_un    = 1'b0;
            model_valid = 1'b0;
        end else begin
            pa = p_pop && (sz > 0);
            wa = p_push && ((sz < 4) || pa);
            if (pa) begin
                sb_q.push_back(model_q[sz-1]);
                void'(model_q.pop_back());
            end
            if (wa) model_q.push_back(p_data);
            if (p_push && !wa) model_ov = 1'b1;
            else if (p_clr) model_ov = 1'b0;
            if (p_pop && (sz == 0)) model_un = 1'b1;
            else if (p_clr) model_un = 1'b0;
            model_valid = pa;
        end
        @(posedge clk);
        #1;
        checkState(tag);
    endtask

    // Scoreboard monitor: each presented pop must match the oldest expectation.
    always @(negedge clk) begin
        logic [3:0] exp_word;
        if (pop_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_data: unexpected pop_valid with data %0d, none expected", pop_data);
            end else begin
                exp_word = sb_q.pop_front();
                if (pop_data !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL pop_data: got %0d expected %0d at %0t", pop_data, exp_word, $time);
                end
            end
        end
    end

    initial begin
        push = 0; pop = 0; push_data = 0; clr_err = 0; rst = 1;
        $display("[TB] starting lifo_stack bench");

        applyStimulus(0, 0, 0, 0, 1, "reset0");
        applyStimulus(0, 0, 0, 0, 1, "reset1");
        checkOutput("reset.pop_data", pop_data, 0);

        // Push 1..4 then pop 4 times: pops come back 4,3,2,1.
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 4'(i), 0, 0, "fill");
        checkOutput("fill.full", full, 1);
        applyStimulus(0, 1, 0, 0, 0, "drain");
        checkOutput("drain.first_pop_data", pop_data, 4);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, "drain");
        checkOutput("drain.last_pop_data", pop_data, 1);
        checkOutput("drain.empty", empty, 1);

        // Overflow on full, then clear.
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 4'(i), 0, 0, "fill2");
        applyStimulus(1, 0, 9, 0, 0, "overflow");
        checkOutput("overflow.flag", overflow, 1);
        checkOutput("overflow.count", count, 4);
        checkOutput("overflow.top", top_data, 4);
        applyStimulus(0, 0, 0, 1, 0, "clr_ov");
        checkOutput("clr_ov.flag", overflow, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, "drain2");

        // Underflow on empty; push+pop on empty still takes the push.
        applyStimulus(0, 1, 0, 0, 0, "underflow");
        checkOutput("underflow.flag", underflow, 1);
        checkOutput("underflow.valid", pop_valid, 0);
        applyStimulus(1, 1, 5, 0, 0, "empty_pushpop");
        checkOutput("empty_pushpop.count", count, 1);
        checkOutput("empty_pushpop.top", top_data, 5);
        checkOutput("empty_pushpop.underflow", underflow, 1);
        applyStimulus(0, 1, 0, 1, 0, "clr_un");
        checkOutput("clr_un.flag", underflow, 0);

        // Replace: stack 1,2 then push 7 with pop.
        applyStimulus(1, 0, 1, 0, 0, "rep_fill");
        applyStimulus(1, 0, 2, 0, 0, "rep_fill");
        applyStimulus(1, 1, 7, 0, 0, "replace");
        checkOutput("replace.pop_data", pop_data, 2);
        checkOutput("replace.count", count, 2);
        checkOutput("replace.top", top_data, 7);
        applyStimulus(1, 0, 3, 0, 0, "rep_fill");
        applyStimulus(1, 0, 4, 0, 0, "rep_fill");
        applyStimulus(1, 1, 8, 0, 0, "replace_full");
        checkOutput("replace_full.overflow", overflow, 0);
        checkOutput("replace_full.pop_data", pop_data, 4);
        checkOutput("replace_full.top", top_data, 8);

        // Almost-full threshold and reset discarding a push.
        applyStimulus(0, 0, 0, 0, 1, "reset2");
        for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 4'(i), 0, 0, "af_fill");
        checkOutput("af.almost_full", almost_full, 1);
        applyStimulus(1, 0, 4, 0, 1, "reset_push");
        checkOutput("reset_push.count", count, 0);
        checkOutput("reset_push.empty", empty, 1);
        checkOutput("reset_push.almost_full", almost_full, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), 0, "random");
        end
        applyStimulus(0, 0, 0, 0, 0, "idle");

        checkOutput("scoreboard.leftover", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
